// File: rtl/setting_state.sv
// setting_state
// Writer side of the timer's MM:SS BCD setting bus. Raw push-button levels
// are synchronised and edge-detected, then used to move a digit cursor and
// to step the selected digit up or down within its legal BCD range, with
// hold-to-repeat on increment/decrement. A blink strobe lets the display
// highlight the cursor digit.
//
// Ports:
//   clk           system clock
//   reset         asynchronous, active-low reset
//   isSetting     high while the top-level FSM is in setting mode
//   btnSelect     raw level, advances the cursor
//   btnIncrement  raw level, +1 on the cursor digit
//   btnDecrement  raw level, -1 on the cursor digit
//   btnClear      raw level, zeroes all digits
//   setting0      seconds ones, BCD 0-9
//   setting1      seconds tens, BCD 0-5
//   setting2      minutes ones, BCD 0-9
//   setting3      minutes tens, BCD 0-9
//   cursor        index of the selected digit, 0-3
//   blink         blink strobe for the cursor digit
//   isNonZero     high when any setting digit is nonzero
module setting_state #(
    parameter int REPEAT_DELAY = 12500000,
    parameter int REPEAT_RATE  = 5000000,
    parameter int BLINK_CYCLES = 12500000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       isSetting,
    input  logic       btnSelect,
    input  logic       btnIncrement,
    input  logic       btnDecrement,
    input  logic       btnClear,
    output logic [3:0] setting0,
    output logic [3:0] setting1,
    output logic [3:0] setting2,
    output logic [3:0] setting3,
    output logic [1:0] cursor,
    output logic       blink,
    output logic       isNonZero
);

    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);

    // Button vector layout: bit0 select, bit1 increment, bit2 decrement, bit3 clear.
    logic [3:0]    rawBtn;
    logic [3:0]    sync0;
    logic [3:0]    sync1;
    logic [3:0]    prevBtn;
    logic [3:0]    pressPulse;

    logic [RW-1:0] repCnt [2];
    logic [1:0]    repeatHit;

    logic          selAct;
    logic          incAct;
    logic          decAct;
    logic          clrAct;

    logic [3:0]    digit [4];
    logic [3:0]    curDigit;
    logic [3:0]    maxDigit;
    logic [3:0]    incVal;
    logic [3:0]    decVal;

    logic [BW-1:0] blinkCnt;

    assign rawBtn     = {btnClear, btnDecrement, btnIncrement, btnSelect};
    assign pressPulse = sync1 & ~prevBtn;

    // Two-flop synchroniser per button followed by a previous-value flop,
    // so a press becomes a single-cycle pulse on the synchronised rising edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync0   <= '0;
            sync1   <= '0;
            prevBtn <= '0;
        end else begin
            sync0   <= rawBtn;
            sync1   <= sync0;
            prevBtn <= sync1;
        end
    end

    // A repeat step fires on the cycle the hold counter would reach
    // REPEAT_DELAY; the press pulse itself is the first step, so a pulse
    // cycle never also produces a repeat step.
    always_comb begin
        repeatHit = '0;
        for (int i = 0; i < 2; i++) begin
            repeatHit[i] = sync1[i+1] & isSetting & ~pressPulse[i+1] &
                           (repCnt[i] == RW'(REPEAT_DELAY - 1));
        end
    end

    // Hold counters for increment (index 0) and decrement (index 1). They
    // restart on a press, run while the synchronised button stays high in
    // setting mode, and reload after each repeat step so that the following
    // steps come every REPEAT_RATE cycles. Release or leaving setting mode
    // clears them so no stale step can be issued.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                repCnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (pressPulse[i+1]) begin
                    repCnt[i] <= '0;
                end else if (sync1[i+1] && isSetting) begin
                    if (repCnt[i] == RW'(REPEAT_DELAY - 1)) begin
                        repCnt[i] <= RW'(REPEAT_DELAY - REPEAT_RATE);
                    end else begin
                        repCnt[i] <= repCnt[i] + 1'b1;
                    end
                end else begin
                    repCnt[i] <= '0;
                end
            end
        end
    end

    // Actions only count in setting mode; outside it every button is ignored.
    assign selAct = pressPulse[0] & isSetting;
    assign incAct = (pressPulse[1] | repeatHit[0]) & isSetting;
    assign decAct = (pressPulse[2] | repeatHit[1]) & isSetting;
    assign clrAct = pressPulse[3] & isSetting;

    // Wrapped next values for the cursor digit; the seconds-tens digit
    // only spans 0-5, every other digit spans 0-9.
    always_comb begin
        curDigit = digit[cursor];
        maxDigit = (cursor == 2'd1) ? 4'd5 : 4'd9;
        incVal   = (curDigit == maxDigit) ? 4'd0 : curDigit + 4'd1;
        decVal   = (curDigit == 4'd0) ? maxDigit : curDigit - 4'd1;
    end

    // Digit and cursor registers. Clear beats select, select beats
    // increment/decrement, and simultaneous increment and decrement cancel.
    // Dropped lower-priority actions are simply lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                digit[i] <= 4'd0;
            end
            cursor <= 2'd0;
        end else if (clrAct) begin
            for (int i = 0; i < 4; i++) begin
                digit[i] <= 4'd0;
            end
        end else if (selAct) begin
            cursor <= cursor + 2'd1;
        end else if (incAct && !decAct) begin
            digit[cursor] <= incVal;
        end else if (decAct && !incAct) begin
            digit[cursor] <= decVal;
        end
    end

    // Blink strobe: free-running half-period counter in setting mode, forced
    // on by any edit so the digit being changed is visible at once, and held
    // off outside setting mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            blinkCnt <= '0;
            blink    <= 1'b0;
        end else if (!isSetting) begin
            blinkCnt <= '0;
            blink    <= 1'b0;
        end else if (selAct || incAct || decAct) begin
            blinkCnt <= '0;
            blink    <= 1'b1;
        end else if (blinkCnt == BW'(BLINK_CYCLES - 1)) begin
            blinkCnt <= '0;
            blink    <= ~blink;
        end else begin
            blinkCnt <= blinkCnt + 1'b1;
        end
    end

    assign setting0  = digit[0];
    assign setting1  = digit[1];
    assign setting2  = digit[2];
    assign setting3  = digit[3];
    assign isNonZero = |{setting3, setting2, setting1, setting0};

endmodule

// File: tb/tb_setting_state.sv
// tb_setting_state
// Self-checking bench for setting_state. A behavioural model tracks the digit
// values, cursor, blink level and hold ages from the button rules and is
// compared against the DUT after every clock edge; directed sequences with
// literal expectations pin the model, followed by randomized stimulus.
module tb_setting_state;

    localparam int D = 8;
    localparam int R = 4;
    localparam int B = 5;

    logic       clk;
    logic       reset;
    logic       isSetting;
    logic       btnSelect;
    logic       btnIncrement;
    logic       btnDecrement;
    logic       btnClear;
    logic [3:0] setting0;
    logic [3:0] setting1;
    logic [3:0] setting2;
    logic [3:0] setting3;
    logic [1:0] cursor;
    logic       blink;
    logic       isNonZero;

    int testsRun    = 0;
    int testsFailed = 0;

    // Model state: digit values, cursor, blink level, cycles since the last
    // blink toggle/force, hold ages and the last three raw samples.
    int         mDigit [4];
    int         mCursor;
    int         mBlink;
    int         mPhase;
    int         incAge;
    int         decAge;
    logic [3:0] r1;
    logic [3:0] r2;
    logic [3:0] r3;

    setting_state #(
        .REPEAT_DELAY (D),
        .REPEAT_RATE  (R),
        .BLINK_CYCLES (B)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .isSetting    (isSetting),
        .btnSelect    (btnSelect),
        .btnIncrement (btnIncrement),
        .btnDecrement (btnDecrement),
        .btnClear     (btnClear),
        .setting0     (setting0),
        .setting1     (setting1),
        .setting2     (setting2),
        .setting3     (setting3),
        .cursor       (cursor),
        .blink        (blink),
        .isNonZero    (isNonZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // One clock edge of the model. A press is a raw rise seen two samples
    // back; a held button issues a step after D cycles of hold and every R
    // cycles after that.
    task automatic modelStep();
        logic [3:0] pulse;
        bit incStep, decStep, sel, clr, inc, dec;
        int lim;
        if (!reset) begin
            for (int i = 0; i < 4; i++) mDigit[i] = 0;
            mCursor = 0;
            mBlink  = 0;
            mPhase  = 0;
            incAge  = 0;
            decAge  = 0;
            r1 = '0;
            r2 = '0;
            r3 = '0;
        end else begin
            pulse = r2 & ~r3;
            incStep = 0;
            decStep = 0;
            if (pulse[1]) begin
                incAge = 0;
                incStep = 1;
            end else if (r2[1] && isSetting) begin
                incAge++;
                incStep = (incAge >= D) && ((incAge - D) % R == 0);
            end else begin
                incAge = 0;
            end
            if (pulse[2]) begin
                decAge = 0;
                decStep = 1;
            end else if (r2[2] && isSetting) begin
                decAge++;
                decStep = (decAge >= D) && ((decAge - D) % R == 0);
            end else begin
                decAge = 0;
            end
            sel = isSetting && pulse[0];
            clr = isSetting && pulse[3];
            inc = isSetting && incStep;
            dec = isSetting && decStep;
            lim = (mCursor == 1) ? 6 : 10;
            if (clr) begin
                for (int i = 0; i < 4; i++) mDigit[i] = 0;
            end else if (sel) begin
                mCursor = (mCursor + 1) % 4;
            end else if (inc && !dec) begin
                mDigit[mCursor] = (mDigit[mCursor] + 1) % lim;
            end else if (dec && !inc) begin
                mDigit[mCursor] = (mDigit[mCursor] + lim - 1) % lim;
            end
            if (!isSetting) begin
                mBlink = 0;
                mPhase = 0;
            end else if (sel || inc || dec) begin
                mBlink = 1;
                mPhase = 0;
            end else begin
                mPhase++;
                if (mPhase == B) begin
                    mBlink = 1 - mBlink;
                    mPhase = 0;
                end
            end
            r3 = r2;
            r2 = r1;
            r1 = {btnClear, btnDecrement, btnIncrement, btnSelect};
        end
    endtask

    // Compare process: advance the model on each rising edge and check every
    // DUT output shortly after it.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            #1;
            checkOutput("model_setting0", int'(setting0), mDigit[0]);
            checkOutput("model_setting1", int'(setting1), mDigit[1]);
            checkOutput("model_setting2", int'(setting2), mDigit[2]);
            checkOutput("model_setting3", int'(setting3), mDigit[3]);
            checkOutput("model_cursor", int'(cursor), mCursor);
            checkOutput("model_blink", int'(blink), mBlink);
            checkOutput("model_nonzero", int'(isNonZero),
                        (mDigit[0] | mDigit[1] | mDigit[2] | mDigit[3]) != 0 ? 1 : 0);
        end
    end

    // Raise the given buttons for one cycle, then wait until the resulting
    // update edge has passed.
    task automatic applyStimulus(input logic sel, input logic inc, input logic dec, input logic clr);
        @(negedge clk);
        btnSelect    = sel;
        btnIncrement = inc;
        btnDecrement = dec;
        btnClear     = clr;
        @(negedge clk);
        btnSelect    = 1'b0;
        btnIncrement = 1'b0;
        btnDecrement = 1'b0;
        btnClear     = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int incSeq [5];
        incSeq = '{2, 3, 4, 5, 0};

        reset        = 1'b0;
        isSetting    = 1'b0;
        btnSelect    = 1'b0;
        btnIncrement = 1'b0;
        btnDecrement = 1'b0;
        btnClear     = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_setting0", int'(setting0), 0);
        checkOutput("reset_setting1", int'(setting1), 0);
        checkOutput("reset_cursor", int'(cursor), 0);
        checkOutput("reset_blink", int'(blink), 0);
        checkOutput("reset_nonzero", int'(isNonZero), 0);
        reset     = 1'b1;
        isSetting = 1'b1;

        applyStimulus(1, 0, 0, 0);
        checkOutput("select_to_1", int'(cursor), 1);

        @(negedge clk);
        btnIncrement = 1'b1;
        @(posedge clk);
        @(negedge clk);
        btnIncrement = 1'b0;
        checkOutput("latency_edge0", int'(setting1), 0);
        @(posedge clk);
        #1;
        checkOutput("latency_edge1", int'(setting1), 0);
        @(posedge clk);
        #1;
        checkOutput("latency_edge2", int'(setting1), 1);
        checkOutput("blink_on_inc", int'(blink), 1);
        checkOutput("nonzero_after_write", int'(isNonZero), 1);

        for (int k = 0; k < 5; k++) begin
            applyStimulus(0, 1, 0, 0);
            checkOutput("inc_seq_setting1", int'(setting1), incSeq[k]);
        end
        checkOutput("inc_seq_setting0", int'(setting0), 0);
        checkOutput("inc_seq_setting2", int'(setting2), 0);

        applyStimulus(1, 0, 0, 0);
        checkOutput("select_to_2", int'(cursor), 2);
        applyStimulus(1, 0, 0, 0);
        checkOutput("select_to_3", int'(cursor), 3);
        applyStimulus(1, 0, 0, 0);
        checkOutput("select_wrap_0", int'(cursor), 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("dec_wrap_digit0", int'(setting0), 9);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("dec_wrap_digit1", int'(setting1), 5);

        applyStimulus(1, 0, 0, 0);
        @(negedge clk);
        btnIncrement = 1'b1;
        repeat (30) @(negedge clk);
        btnIncrement = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("hold_repeat", int'(setting2), 7);
        repeat (10) @(negedge clk);
        checkOutput("hold_release", int'(setting2), 7);
        checkOutput("nonzero_before_clear", int'(isNonZero), 1);

        applyStimulus(0, 1, 0, 1);
        checkOutput("clear_inc_setting0", int'(setting0), 0);
        checkOutput("clear_inc_setting1", int'(setting1), 0);
        checkOutput("clear_inc_setting2", int'(setting2), 0);
        checkOutput("clear_keeps_cursor", int'(cursor), 2);
        checkOutput("nonzero_after_clear", int'(isNonZero), 0);

        applyStimulus(0, 1, 0, 0);
        applyStimulus(0, 1, 1, 0);
        checkOutput("inc_dec_cancel", int'(setting2), 1);

        @(negedge clk);
        isSetting = 1'b0;
        applyStimulus(1, 1, 0, 0);
        applyStimulus(0, 0, 1, 1);
        checkOutput("idle_setting2", int'(setting2), 1);
        checkOutput("idle_cursor", int'(cursor), 2);
        checkOutput("idle_blink", int'(blink), 0);

        @(negedge clk);
        isSetting = 1'b1;
        repeat (3) @(negedge clk);
        btnIncrement = 1'b1;
        @(posedge clk);
        @(negedge clk);
        btnIncrement = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("blink_forced", int'(blink), 1);
        repeat (4) @(posedge clk);
        #1;
        checkOutput("blink_hold_4", int'(blink), 1);
        @(posedge clk);
        #1;
        checkOutput("blink_toggle_5", int'(blink), 0);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("blink_toggle_10", int'(blink), 1);

        applyStimulus(0, 0, 0, 1);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        applyStimulus(1, 0, 0, 0);
        for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, 0);
        applyStimulus(1, 0, 0, 0);
        applyStimulus(0, 0, 1, 0);
        checkOutput("preset_setting0", int'(setting0), 3);
        checkOutput("preset_setting1", int'(setting1), 5);
        checkOutput("preset_setting2", int'(setting2), 9);
        checkOutput("preset_setting3", int'(setting3), 9);

        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async_setting0", int'(setting0), 0);
        checkOutput("async_setting1", int'(setting1), 0);
        checkOutput("async_setting2", int'(setting2), 0);
        checkOutput("async_setting3", int'(setting3), 0);
        checkOutput("async_cursor", int'(cursor), 0);
        checkOutput("async_nonzero", int'(isNonZero), 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_held_setting3", int'(setting3), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            reset     = 1'b1;
            btnSelect = ($urandom_range(0, 19) == 0);
            btnClear  = ($urandom_range(0, 59) == 0);
            if (btnIncrement) btnIncrement = ($urandom_range(0, 15) != 0);
            else              btnIncrement = ($urandom_range(0, 9) == 0);
            if (btnDecrement) btnDecrement = ($urandom_range(0, 15) != 0);
            else              btnDecrement = ($urandom_range(0, 11) == 0);
            if (isSetting) begin
                if ($urandom_range(0, 149) == 0) isSetting = 1'b0;
            end else begin
                if ($urandom_range(0, 19) == 0) isSetting = 1'b1;
            end
            if ($urandom_range(0, 599) == 0) begin
                #2;
                reset = 1'b0;
            end
        end

        @(negedge clk);
        reset        = 1'b1;
        btnSelect    = 1'b0;
        btnIncrement = 1'b0;
        btnDecrement = 1'b0;
        btnClear     = 1'b0;
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/setting_state.md
Name: setting_state

Overview:
- Writer side of the timer's MM:SS BCD digit bus: builds the four setting digits that the running countdown loads on start.
- Takes raw push-button levels, synchronises them, detects edges, and moves a digit cursor.
- Increments or decrements the selected digit within its legal BCD range, with hold-to-repeat.
- Drives a blink strobe so the display can highlight the cursor digit; sits between the button pins and the countdown block.

Parameters:
- REPEAT_DELAY, 12500000, clk cycles an inc/dec button must be held (after its first edge) before auto-repeat starts; must be >= 1.
- REPEAT_RATE, 5000000, clk cycles between auto-repeat steps once repeating; must be >= 1.
- BLINK_CYCLES, 12500000, clk cycles per blink half-period; must be >= 1.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- isSetting  input  1  high while the top-level FSM is in setting mode; all buttons are ignored when low.
- btnSelect  input  1  raw level, advances the cursor.
- btnIncrement  input  1  raw level, +1 on the cursor digit.
- btnDecrement  input  1  raw level, -1 on the cursor digit.
- btnClear  input  1  raw level, zeroes all digits.
- setting0  output  4  seconds ones, BCD 0-9.
- setting1  output  4  seconds tens, BCD 0-5.
- setting2  output  4  minutes ones, BCD 0-9.
- setting3  output  4  minutes tens, BCD 0-9.
- cursor  output  2  index of the selected digit, 0-3.
- blink  output  1  blink strobe for the cursor digit.
- isNonZero  output  1  high when any setting digit is nonzero.

Behaviour:
- Reset (reset=0, asynchronous): setting0-3=0, cursor=0, blink=0, all synchronisers, edge registers and counters cleared. isNonZero=0 follows from the digits.
- Input path, per button: two-flop synchroniser (s0, s1), then a prev flop. Press pulse = s1 & ~prev.
  - A raw 0->1 transition meeting setup before edge E becomes visible on outputs after edge E+2 (3-edge latency).
- Action pulses are qualified by isSetting, sampled on the same edge as the update.
- Priority when several pulses coincide: clear > select > increment/decrement.
  - inc and dec pulses in the same cycle: no digit change.
  - Lower-priority pulses in that cycle are dropped, not queued.
- Clear: all four digits -> 0; cursor unchanged.
- Select: cursor 0->1->2->3->0 (wraps).
- Increment on the cursor digit:
  - digits 0, 2, 3: 9 -> 0.
  - digit 1: 5 -> 0.
  - No carry into neighbouring digits.
- Decrement: 0 -> 9 (digits 0, 2, 3); 0 -> 5 (digit 1); no borrow.
- Auto-repeat, separate counter per inc and dec:
  - Counter starts at 0 on the press pulse and counts every cycle while s1 stays high and isSetting=1.
  - On reaching REPEAT_DELAY: one extra step, counter reloads to REPEAT_DELAY-REPEAT_RATE.
  - Thereafter one step every REPEAT_RATE cycles.
  - Release, or isSetting=0: counter resets to 0 and no step is issued.
  - Repeat steps obey the same priority and wrap rules as press pulses.
- Blink:
  - While isSetting=1: free-running counter toggles blink every BLINK_CYCLES cycles.
  - blink is forced to 1 (counter cleared) on any select, inc or dec action, so the edited digit is immediately visible.
  - While isSetting=0: blink=0 and the counter is held at 0.
- isSetting=0: digits and cursor hold their values. isSetting mid-hold stops repeat immediately.
- Illegal digit values cannot occur: only reset, clear, inc and dec write digits.
- isNonZero: combinational OR of the digit-nonzero terms from registered digits; the countdown must not start when it is 0.

Test Plan:
- Use REPEAT_DELAY=8, REPEAT_RATE=4, BLINK_CYCLES=5.
- Reset asserted mid-operation (digits 3,5,9,9) -> all outputs 0 immediately without a clk edge; held at 0 until reset=1.
- isSetting=1, cursor=1, 6 single inc presses from 0 -> setting1 sequence 1,2,3,4,5,0; each change lands exactly 3 edges after the raw rise; other digits stay 0.
- Cursor=0, dec press from 0 -> setting0=9; select x4 -> cursor 1,2,3,0; dec at cursor=1 from 0 -> 5.
- Hold inc 30 cycles at cursor=2 from 0 -> steps at press, +8, +12, +16, +20, +24, +28 -> setting2=7; release -> no further change.
- Same-cycle clear+inc -> all digits 0, no increment. Same-cycle inc+dec -> digit unchanged. isSetting=0 with presses -> nothing changes and blink=0.
- isSetting=1 idle -> blink toggles every 5 cycles. Inc press -> blink=1 on the update edge. isNonZero goes 0 -> 1 after the first nonzero write and back to 0 after clear.
